fusion_accumulator: RTL

- Consumer end of the fusion unit's packed 64-bit product bus.
- Unpacks each beat into 1, 2 or 4 lanes according to the operand precision config.
- Sign- or zero-extends each lane and accumulates it, saturating, into per-lane accumulators over a group of beats terminated by in_last.
- Presents one packed result per group through a valid/ready handshake to the output/writeback stage.

---
 rtl/fusion_pkg.sv | 42 ++++
 rtl/sat_lane_acc.sv | 64 ++++++
 rtl/fusion_accumulator.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/fusion_pkg.sv
// Shared types and decode helpers for the fusion product accumulator.
package fusion_pkg;

  localparam logic [1:0] PREC_8B = 2'b10;
  localparam logic [1:0] PREC_4B = 2'b01;
  localparam logic [1:0] PREC_2B = 2'b00;

  typedef enum logic [1:0] {LM_1X64, LM_2X32, LM_4X16, LM_ILLEGAL} lane_mode_e;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_e;

  // Map an operand precision pair onto the product lane layout.
  function automatic lane_mode_e decode_lane_mode(input logic [1:0] cfga, input logic [1:0] cfgb);
    lane_mode_e mode;
    case ({cfga, cfgb})
      {PREC_8B, PREC_8B}: mode = LM_1X64;
      {PREC_8B, PREC_4B},
      {PREC_4B, PREC_8B}: mode = LM_2X32;
      {PREC_8B, PREC_2B},
      {PREC_2B, PREC_8B},
      {PREC_4B, PREC_4B},
      {PREC_4B, PREC_2B},
      {PREC_2B, PREC_4B},
      {PREC_2B, PREC_2B}: mode = LM_4X16;
      default:            mode = LM_ILLEGAL;
    endcase
    return mode;
  endfunction

  // Number of active lanes for a layout, as reported with each result.
  function automatic logic [2:0] lane_count(input lane_mode_e mode);
    logic [2:0] n;
    case (mode)
      LM_1X64: n = 3'd1;
      LM_2X32: n = 3'd2;
      LM_4X16: n = 3'd4;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/sat_lane_acc.sv
// One accumulator lane: extends the slot, adds it to the lane total and clamps.
module sat_lane_acc
  import fusion_pkg::*;
#(
  parameter int ACC_W = 32
) (
  input  logic [ACC_W-1:0] acc,
  input  logic [63:0]      slot,
  input  lane_mode_e       mode,
  input  logic             is_signed,
  input  logic             clear,
  input  logic             load,
  input  logic             enable,
  output logic [ACC_W-1:0] acc_next,
  output logic             sat
);

  // Wide enough that the sum of any slot and any accumulator never wraps.
  localparam int SUM_W = ((ACC_W > 64) ? ACC_W : 64) + 2;

  localparam logic [SUM_W-1:0] MAX_S = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic [SUM_W-1:0] MIN_S = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
  localparam logic [SUM_W-1:0] MAX_U = {{(SUM_W-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  logic [SUM_W-1:0] slot_ext;
  logic [SUM_W-1:0] base;
  logic [SUM_W-1:0] sum;
  logic [ACC_W-1:0] clamped;
  logic             hit;

  // Extend, add and clamp; a first beat starts from zero instead of the old total.
  always_comb begin
    case (mode)
      LM_1X64: slot_ext = {{(SUM_W-64){is_signed & slot[63]}}, slot};
      LM_2X32: slot_ext = {{(SUM_W-32){is_signed & slot[31]}}, slot[31:0]};
      default: slot_ext = {{(SUM_W-16){is_signed & slot[15]}}, slot[15:0]};
    endcase
    base = load ? '0 : {{(SUM_W-ACC_W){is_signed & acc[ACC_W-1]}}, acc};
    sum = base + slot_ext;
    hit = 1'b0;
    clamped = sum[ACC_W-1:0];
    if (is_signed) begin
      if ($signed(sum) > $signed(MAX_S)) begin
        clamped = MAX_S[ACC_W-1:0];
        hit = 1'b1;
      end else if ($signed(sum) < $signed(MIN_S)) begin
        clamped = MIN_S[ACC_W-1:0];
        hit = 1'b1;
      end
    end else if (sum > MAX_U) begin
      clamped = MAX_U[ACC_W-1:0];
      hit = 1'b1;
    end
    acc_next = acc;
    sat = 1'b0;
    if (clear) begin
      acc_next = '0;
    end else if (load || enable) begin
      acc_next = clamped;
      sat = hit;
    end
  end

endmodule

// File: rtl/fusion_accumulator.sv
// Consumer of the packed fusion product bus: per-lane saturating group accumulation.
module fusion_accumulator
  import fusion_pkg::*;
#(
  parameter int ACC_W     = 32,
  parameter int MAX_BEATS = 256,
  parameter int BEAT_W    = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [63:0]        in_data,
  input  logic               in_last,
  input  logic [1:0]         cfga,
  input  logic [1:0]         cfgb,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [4*ACC_W-1:0] out_data,
  output logic [2:0]         out_lanes,
  output logic [BEAT_W-1:0]  out_beats,
  output logic [3:0]         out_sat,
  output logic               out_forced,
  output logic               err_cfg
);

  state_e            state;
  lane_mode_e        mode_q;
  lane_mode_e        dec_mode;
  lane_mode_e        eff_mode;
  logic              signed_q;
  logic              eff_signed;
  logic [ACC_W-1:0]  acc_q    [4];
  logic [ACC_W-1:0]  acc_next [4];
  logic [63:0]       slot     [4];
  logic [3:0]        sat_hit;
  logic [3:0]        sat_q;
  logic [BEAT_W-1:0] cnt_q;
  logic [BEAT_W-1:0] cnt_next;
  logic [2:0]        lanes_q;
  logic              forced_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              err_cfg_q;
  logic              accept;
  logic              load;
  logic              first_bad;
  logic              enable;
  logic              clear;
  logic              hit_max;

  // The group's layout and signedness come from the live inputs only on its first beat.
  assign dec_mode   = decode_lane_mode(cfga, cfgb);
  assign eff_mode   = (state == IDLE) ? dec_mode : mode_q;
  assign eff_signed = (state == IDLE) ? in_signed : signed_q;

  assign accept    = in_valid && in_ready_q;
  assign load      = accept && (state == IDLE) && (dec_mode != LM_ILLEGAL);
  assign first_bad = accept && (state == IDLE) && (dec_mode == LM_ILLEGAL);
  assign enable    = accept && (state == ACCUM);
  assign clear     = (state == DRAIN) && out_ready;
  assign cnt_next  = (state == IDLE) ? BEAT_W'(1) : cnt_q + BEAT_W'(1);
  assign hit_max   = (cnt_next == BEAT_W'(MAX_BEATS));

  // Slice the product word into lane slots; inactive lanes see zero and stay at zero.
  always_comb begin
    slot[0] = '0;
    slot[1] = '0;
    slot[2] = '0;
    slot[3] = '0;
    case (eff_mode)
      LM_1X64: slot[0] = in_data;
      LM_2X32: begin
        slot[0] = {32'd0, in_data[31:0]};
        slot[1] = {32'd0, in_data[63:32]};
      end
      LM_4X16: begin
        slot[0] = {48'd0, in_data[15:0]};
        slot[1] = {48'd0, in_data[31:16]};
        slot[2] = {48'd0, in_data[47:32]};
        slot[3] = {48'd0, in_data[63:48]};
      end
      default: ;
    endcase
  end

  for (genvar i = 0; i < 4; i++) begin : g_lane
    sat_lane_acc #(.ACC_W(ACC_W)) u_lane (
      .acc       (acc_q[i]),
      .slot      (slot[i]),
      .mode      (eff_mode),
      .is_signed (eff_signed),
      .clear     (clear),
      .load      (load),
      .enable    (enable),
      .acc_next  (acc_next[i]),
      .sat       (sat_hit[i])
    );
  end

  // Lane totals; the lane cells decide whether each cycle holds, loads, adds or clears.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) acc_q[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) acc_q[i] <= acc_next[i];
    end
  end

  // Group sequencing with registered handshake and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      mode_q      <= LM_1X64;
      signed_q    <= 1'b0;
      cnt_q       <= '0;
      sat_q       <= '0;
      lanes_q     <= '0;
      forced_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      err_cfg_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (load) begin
            mode_q   <= dec_mode;
            signed_q <= in_signed;
            lanes_q  <= lane_count(dec_mode);
            cnt_q    <= cnt_next;
            sat_q    <= sat_hit;
            forced_q <= 1'b0;
            if (in_last || hit_max) begin
              state       <= DRAIN;
              forced_q    <= !in_last;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end else if (first_bad) begin
            err_cfg_q <= 1'b1;
          end
        end
        ACCUM: begin
          if (enable) begin
            cnt_q <= cnt_next;
            sat_q <= sat_q | sat_hit;
            if (in_last || hit_max) begin
              state       <= DRAIN;
              forced_q    <= !in_last;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            state       <= IDLE;
            cnt_q       <= '0;
            sat_q       <= '0;
            forced_q    <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Pack the lane totals onto the result bus.
  always_comb begin
    out_data = '0;
    for (int i = 0; i < 4; i++) out_data[i*ACC_W +: ACC_W] = acc_q[i];
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign out_lanes  = lanes_q;
  assign out_beats  = cnt_q;
  assign out_sat    = sat_q;
  assign out_forced = forced_q;
  assign err_cfg    = err_cfg_q;

endmodule
